// File: rtl/risc_pkg.sv
// Shared types and encodings for the multi-cycle RV32 subset core.
package risc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [0:0] {
        ALU_ADD,
        ALU_SUB
    } alu_op_t;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    // Sign-extended immediate for the selected instruction format.
    function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_t sel);
        case (sel)
            IMM_I:   return {{20{ir[31]}}, ir[31:20]};
            IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/mc_reg_file.sv
// Architectural register file: two async read ports, one sync write port, x0 fixed at zero.
module mc_reg_file #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] a0
);
    localparam int unsigned IW = $clog2(NUM_REGS);

    logic [31:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr[IW-1:0]] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1[IW-1:0]];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2[IW-1:0]];
    assign a0     = regs[10];

endmodule

// File: rtl/risc_multicycle.sv
// Multi-cycle RV32 subset core with a single stallable req/ack memory port.
module risc_multicycle
    import risc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           a0,
    output logic                  halted
);
    localparam int unsigned    AW       = ADDR_WIDTH;
    localparam bit             SMALL_RF = (NUM_REGS == 16);
    localparam logic [AW-1:0]  PC_RST   = AW'(RESET_PC);
    localparam logic [AW-1:0]  PC_STEP  = AW'(4);

    state_t        state;
    logic [AW-1:0] pc;
    logic [31:0]   ir, mdr, aluout, a_q, b_q, imm_q;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic [31:0] rs1_val, rs2_val, rf_wdata;
    logic        rf_we;

    mc_reg_file #(.NUM_REGS(NUM_REGS)) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .rdata1 (rs1_val),
        .raddr2 (rs2),
        .rdata2 (rs2_val),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata),
        .a0     (a0)
    );

    function automatic logic reg_ok(input logic [4:0] idx);
        return !(SMALL_RF && idx[4]);
    endfunction

    imm_t        imm_sel;
    alu_op_t     alu_op;
    logic        legal, writes_rd;
    logic [31:0] imm_c, b_imm, j_imm;

    assign b_imm = imm_gen(ir, IMM_B);
    assign j_imm = imm_gen(ir, IMM_J);
    assign imm_c = imm_gen(ir, imm_sel);

    // Instruction decode and legality; targets must stay word aligned.
    always_comb begin
        imm_sel   = IMM_I;
        alu_op    = ALU_ADD;
        legal     = 1'b0;
        writes_rd = 1'b0;
        case (opcode)
            OP_IMM: begin
                writes_rd = 1'b1;
                legal     = (f3 == F3_ADD) && reg_ok(rd) && reg_ok(rs1);
            end
            OP_REG: begin
                writes_rd = 1'b1;
                alu_op    = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
                legal     = (f3 == F3_ADD) && ((f7 == F7_ADD) || (f7 == F7_SUB))
                            && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
            end
            OP_LOAD: begin
                writes_rd = 1'b1;
                legal     = (f3 == F3_W) && reg_ok(rd) && reg_ok(rs1);
            end
            OP_STORE: begin
                imm_sel = IMM_S;
                legal   = (f3 == F3_W) && reg_ok(rs1) && reg_ok(rs2);
            end
            OP_BRANCH: begin
                imm_sel = IMM_B;
                legal   = ((f3 == F3_BEQ) || (f3 == F3_BNE)) && reg_ok(rs1) && reg_ok(rs2)
                          && !b_imm[1];
            end
            OP_JAL: begin
                imm_sel   = IMM_J;
                writes_rd = 1'b1;
                legal     = reg_ok(rd) && !j_imm[1];
            end
            default: legal = 1'b0;
        endcase
    end

    logic          is_load, is_store, is_branch, is_jal, taken;
    logic [31:0]   alu_b, alu_res;
    logic [AW-1:0] pc_plus4, pc_target;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign taken     = (a_q == b_q) ^ f3[0];
    assign alu_b     = (opcode == OP_REG) ? b_q : imm_q;
    assign alu_res   = (alu_op == ALU_SUB) ? (a_q - alu_b) : (a_q + alu_b);
    assign pc_plus4  = pc + PC_STEP;
    assign pc_target = pc + AW'(imm_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= PC_RST;
            ir     <= '0;
            mdr    <= '0;
            aluout <= '0;
            a_q    <= '0;
            b_q    <= '0;
            imm_q  <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a_q   <= rs1_val;
                    b_q   <= rs2_val;
                    imm_q <= imm_c;
                    state <= legal ? EXECUTE : HALT;
                end
                EXECUTE: begin
                    aluout <= alu_res;
                    state  <= WB;
                    if (is_branch) begin
                        pc    <= taken ? pc_target : pc_plus4;
                        state <= FETCH;
                    end else if (is_jal) begin
                        aluout <= 32'(pc_plus4);
                        pc     <= pc_target;
                    end else if (is_load || is_store) begin
                        state <= (alu_res[1:0] == 2'b00) ? MEM : HALT;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (is_store) begin
                            pc    <= pc_plus4;
                            state <= FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    if (!is_jal) pc <= pc_plus4;
                    state <= FETCH;
                end
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    assign rf_we    = (state == WB) && writes_rd;
    assign rf_wdata = is_load ? mdr : aluout;

    // Bus outputs decode the state register and are held quiet during reset.
    assign mem_req   = !rst && ((state == FETCH) || (state == MEM));
    assign mem_we    = !rst && (state == MEM) && is_store;
    assign mem_addr  = (state == MEM) ? AW'(aluout) : pc;
    assign mem_wdata = mem_we ? b_q : 32'd0;
    assign halted    = !rst && (state == HALT);

endmodule

// File: tb/tb_risc_multicycle.sv
// Directed bench: table of short programs plus hand-timed bus/reset sequences.
module tb_risc_multicycle;

    localparam logic [6:0]  OPI = 7'b0010011;
    localparam logic [6:0]  OPR = 7'b0110011;
    localparam logic [31:0] ADDI_X20 = 32'h00100A13;

    logic        clk, rst;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, a0;
    logic        halted;

    logic        mem_req16, mem_we16, halted16;
    logic [11:0] mem_addr16;
    logic [31:0] mem_wdata16, a0_16;

    risc_multicycle dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .a0(a0),
        .halted(halted)
    );

    risc_multicycle #(.ADDR_WIDTH(12), .RESET_PC(256), .NUM_REGS(16)) dut16 (
        .clk(clk), .rst(rst), .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16),
        .mem_wdata(mem_wdata16), .mem_rdata(ADDI_X20), .mem_ack(mem_req16), .a0(a0_16),
        .halted(halted16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with programmable wait states.
    logic [31:0] mem [64];
    int          wait_cycles = 0;
    int          cnt = 0;
    logic        hold_we = 1'b0;
    logic        force_ack = 1'b0;

    assign mem_rdata = mem[mem_addr[7:2]];
    assign mem_ack   = force_ack || (mem_req && !(hold_we && mem_we) && (cnt == wait_cycles));

    always @(posedge clk) cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
    always @(posedge clk) if (mem_req && mem_ack && mem_we) mem[mem_addr[7:2]] = mem_wdata;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                          input int rd, input logic [6:0] op);
        logic [31:0] im;
        im = imm;
        return {im[11:0], 5'(rs1), f3, 5'(rd), op};
    endfunction
    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 3'b000, rd, OPI);
    endfunction
    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
    endfunction
    function automatic logic [31:0] rop(input logic [6:0] f7, input int rd, input int rs1,
                                        input int rs2);
        return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), OPR};
    endfunction
    function automatic logic [31:0] sw(input int rs2, input int rs1, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] br(input logic [2:0] f3, input int rs1, input int rs2,
                                       input int imm);
        logic [31:0] im;
        im = imm;
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [31:0] im;
        im = imm;
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
    endfunction

    task automatic reset_on();
        @(posedge clk);
        #1 rst = 1'b1;
        force_ack = 1'b0;
        hold_we = 1'b0;
        @(posedge clk);
    endtask

    task automatic reset_off();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic load_prog(input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                             input logic [31:0] p3, input logic [31:0] p4);
        for (int k = 0; k < 64; k++) mem[k] = '0;
        mem[16] = 32'h7FFF_FFFF;
        mem[17] = 32'h0000_0001;
        mem[0] = p0; mem[1] = p1; mem[2] = p2; mem[3] = p3; mem[4] = p4;
    endtask

    task automatic wait_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    typedef struct {
        logic [31:0] i0, i1, i2;
        int          w;
        logic [31:0] exp_a0;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int cyc, cnt8, stable, we_cnt, we_cyc;
        logic [31:0] we_addr, we_data, nop;
        rst = 1'b1;
        nop = addi(0, 0, 0);

        vecs[0]  = '{addi(10, 0, 5),    nop,                nop,                 0, 32'h5};
        vecs[1]  = '{addi(10, 0, -1),   nop,                nop,                 1, 32'hFFFF_FFFF};
        vecs[2]  = '{addi(5, 0, 7),     addi(6, 0, 9),      rop(7'h00, 10, 5, 6), 0, 32'd16};
        vecs[3]  = '{addi(5, 0, 3),     addi(6, 0, 5),      rop(7'h20, 10, 5, 6), 2, 32'hFFFF_FFFE};
        vecs[4]  = '{addi(5, 0, 2047),  rop(7'h00, 10, 5, 5), nop,               0, 32'hFFE};
        vecs[5]  = '{lw(5, 0, 64),      lw(6, 0, 68),       rop(7'h00, 10, 5, 6), 1, 32'h8000_0000};
        vecs[6]  = '{addi(10, 0, 1),    br(3'b000, 0, 0, 8), addi(10, 0, 99),    0, 32'd1};
        vecs[7]  = '{addi(10, 0, 1),    br(3'b001, 0, 0, 8), addi(10, 10, 2),    0, 32'd3};
        vecs[8]  = '{jal(10, 8),        addi(10, 0, 7),     addi(10, 10, 1),     0, 32'd5};
        vecs[9]  = '{addi(5, 0, 85),    sw(5, 0, 72),       lw(10, 0, 72),       2, 32'h55};
        vecs[10] = '{addi(0, 0, 5),     addi(10, 0, 3),     rop(7'h00, 10, 10, 0), 0, 32'd3};
        vecs[11] = '{addi(10, 0, 4),    lw(11, 0, 66),      addi(10, 0, 9),      0, 32'd4};
        vecs[12] = '{addi(10, 0, 6),    rop(7'h01, 10, 0, 0), addi(10, 0, 9),    0, 32'd6};

        // Zero-wait ADDI timing, then halt on an all-zero word.
        wait_cycles = 0;
        reset_on();
        load_prog(addi(10, 0, 5), 32'h0, 32'h0, 32'h0, 32'h0);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_halted", 32'(halted), 0);
        reset_off();
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("first_fetch_req", 32'(mem_req), 1);
                check("first_fetch_addr", mem_addr, 0);
                check("reset_a0", a0, 0);
                check("rv16_fetch_addr", 32'(mem_addr16), 32'h100);
            end
            if (c == 2) check("req_drop_after_ack", 32'(mem_req), 0);
            if (c == 3) begin
                check("rv16_halted_x20", 32'(halted16), 1);
                check("rv16_req_idle", 32'(mem_req16), 0);
                check("rv16_quiet", {30'd0, mem_we16, |{mem_wdata16, a0_16}}, 0);
            end
            if (c == 4) check("a0_during_wb", a0, 0);
            if (c == 5) begin
                check("second_fetch_req", 32'(mem_req), 1);
                check("second_fetch_addr", mem_addr, 4);
                check("a0_after_wb", a0, 5);
            end
        end
        wait_halt(cyc);
        check("zero_ir_halted", 32'(halted), 1);
        cnt8 = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_req || !halted) cnt8++;
        end
        check("halt_stays_idle", cnt8, 0);
        reset_on();
        reset_off();
        @(negedge clk);
        check("restart_fetch_addr", mem_addr, 0);
        check("restart_not_halted", {31'd0, mem_req, halted}, 2);

        // Table of short programs, each ending in an illegal word.
        for (int v = 0; v < 13; v++) begin
            reset_on();
            wait_cycles = vecs[v].w;
            load_prog(vecs[v].i0, vecs[v].i1, vecs[v].i2, 32'h0, 32'h0);
            reset_off();
            wait_halt(cyc);
            check($sformatf("vec%0d_halted", v), 32'(halted), 1);
            check($sformatf("vec%0d_a0", v), a0, vecs[v].exp_a0);
        end

        // Countdown loop: BNE costs 3 cycles, exit PC verified via final ADDI.
        reset_on();
        wait_cycles = 0;
        load_prog(addi(11, 0, 3), addi(11, 11, -1), br(3'b001, 11, 0, -4), addi(10, 11, 16), 32'h0);
        reset_off();
        cyc = 0;
        cnt8 = 0;
        while (!halted && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_req && mem_addr == 32'd8) cnt8++;
        end
        check("loop_a0", a0, 16);
        check("loop_halt_cycle", cyc, 32);
        check("loop_bne_fetches", cnt8, 3);

        // LW with three wait states on every access.
        reset_on();
        wait_cycles = 3;
        load_prog(lw(10, 0, 64), 32'h0, 32'h0, 32'h0, 32'h0);
        mem[16] = 32'hDEAD_BEEF;
        reset_off();
        stable = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c >= 7 && c <= 10 && mem_req && !mem_we && mem_addr == 32'd64) stable++;
            if (c == 11) check("lw_wb_no_req", {31'd0, mem_req} | a0, 0);
            if (c == 12) begin
                check("lw_next_fetch_addr", mem_addr, 4);
                check("lw_next_fetch_req", 32'(mem_req), 1);
                check("lw_a0", a0, 32'hDEAD_BEEF);
            end
        end
        check("lw_stall_hold", stable, 4);

        // SW x10,8(x0) overwrites the next instruction with an illegal word.
        reset_on();
        wait_cycles = 0;
        load_prog(lw(10, 0, 64), sw(10, 0, 8), addi(10, 0, 1), 32'h0, 32'h0);
        mem[16] = 32'h0000_1234;
        reset_off();
        we_cnt = 0; we_cyc = 0; we_addr = '0; we_data = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_req && mem_we) begin
                we_cnt++;
                we_cyc = c;
                we_addr = mem_addr;
                we_data = mem_wdata;
            end
        end
        check("sw_we_count", we_cnt, 1);
        check("sw_mem_cycle", we_cyc, 9);
        check("sw_addr", we_addr, 8);
        check("sw_wdata", we_data, 32'h1234);
        check("sw_mem_written", mem[2], 32'h1234);
        check("sw_then_halted", 32'(halted), 1);

        // Reset during a stalled store; late ack arrives while rst is high.
        reset_on();
        wait_cycles = 0;
        load_prog(addi(10, 0, 7), sw(10, 0, 64), 32'h0, 32'h0, 32'h0);
        reset_off();
        hold_we = 1'b1;
        cyc = 0;
        while (!(mem_req && mem_we) && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("stall_seen", {31'd0, mem_req && mem_we}, 1);
        stable = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_req && mem_we && mem_addr == 32'd64 && mem_wdata == 32'd7) stable++;
        end
        check("stall_hold", stable, 3);
        check("stall_a0", a0, 7);
        @(posedge clk);
        #1 rst = 1'b1;
        force_ack = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_req", {30'd0, mem_req, mem_we} | mem_wdata, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        force_ack = 1'b0;
        hold_we = 1'b0;
        @(negedge clk);
        check("post_rst_fetch", {mem_addr[29:0], mem_req, mem_we}, 2);
        check("post_rst_a0", a0, 0);
        check("abandoned_store", mem[16], 32'h7FFF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
